// File: rtl/f_pc_unit.sv
// f_pc_unit: fetch-stage program counter and next-PC selector.
// Chooses between sequential fetch, conditional branch, j/jal and jr/jalr
// targets decided in D. The delay-slot instruction already in F is kept.
// Also flags misaligned fetch addresses and counts committed redirects.
//
// Ports:
//   clk           system clock, rising edge
//   reset         asynchronous active-low reset
//   F_en          1 = advance F_pc, 0 = stall (hold all state)
//   D_br_type     000 none, 001 branch, 010 j/jal, 011 jr/jalr, 1xx none
//   D_equal       branch condition for the instruction in D
//   D_pc          PC of the instruction in D
//   D_imm16       branch offset field
//   D_imm26       jump index field
//   D_Rdata1      forwarded rs value (jr/jalr target)
//   F_pc          current fetch address (registered)
//   F_adel        misaligned fetch flag (registered)
//   redirect      combinational: next PC is a non-sequential target
//   redirect_cnt  committed redirect count (registered, wraps)
module f_pc_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_3000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        F_en,
  input  logic [2:0]  D_br_type,
  input  logic        D_equal,
  input  logic [31:0] D_pc,
  input  logic [15:0] D_imm16,
  input  logic [25:0] D_imm26,
  input  logic [31:0] D_Rdata1,
  output logic [31:0] F_pc,
  output logic        F_adel,
  output logic        redirect,
  output logic [31:0] redirect_cnt
);

  localparam int unsigned W = 32;

  localparam logic [2:0] BR_COND = 3'b001;
  localparam logic [2:0] BR_JUMP = 3'b010;
  localparam logic [2:0] BR_REG  = 3'b011;

  logic [W-1:0] r_pc;
  logic         r_adel;
  logic [W-1:0] r_cnt;

  logic [W-1:0] w_seq_pc;
  logic [W-1:0] w_dpc4;
  logic [W-1:0] w_br_off;
  logic [W-1:0] w_br_tgt;
  logic [W-1:0] w_j_tgt;
  logic [W-1:0] w_next_pc;
  logic         w_redirect;

  // Candidate targets, all 32-bit modular.
  always_comb begin
    w_seq_pc = r_pc + W'(4);
    w_dpc4   = D_pc + W'(4);
    w_br_off = {{14{D_imm16[15]}}, D_imm16, 2'b00};
    w_br_tgt = w_dpc4 + w_br_off;
    w_j_tgt  = {w_dpc4[31:28], D_imm26, 2'b00};
  end

  // Next-PC select; 1xx types fall through to sequential fetch.
  always_comb begin
    w_next_pc  = w_seq_pc;
    w_redirect = 1'b0;
    case (D_br_type)
      BR_REG: begin
        w_next_pc  = D_Rdata1;
        w_redirect = 1'b1;
      end
      BR_JUMP: begin
        w_next_pc  = w_j_tgt;
        w_redirect = 1'b1;
      end
      BR_COND: begin
        if (D_equal) begin
          w_next_pc  = w_br_tgt;
          w_redirect = 1'b1;
        end
      end
      default: ;
    endcase
  end

  // PC, misalignment flag and redirect counter; all hold while stalled.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_pc   <= RESET_PC;
      r_adel <= 1'b0;
      r_cnt  <= '0;
    end else if (F_en) begin
      r_pc   <= w_next_pc;
      r_adel <= (w_next_pc[1:0] != 2'b00);
      if (w_redirect) r_cnt <= r_cnt + W'(1);
    end
  end

  assign F_pc         = r_pc;
  assign F_adel       = r_adel;
  assign redirect     = w_redirect;
  assign redirect_cnt = r_cnt;

endmodule

// File: tb/tb_f_pc_unit.sv
// Directed, table-driven bench for f_pc_unit.
module tb_f_pc_unit;

  logic        clk;
  logic        reset;
  logic        F_en;
  logic [2:0]  D_br_type;
  logic        D_equal;
  logic [31:0] D_pc;
  logic [15:0] D_imm16;
  logic [25:0] D_imm26;
  logic [31:0] D_Rdata1;
  logic [31:0] F_pc;
  logic        F_adel;
  logic        redirect;
  logic [31:0] redirect_cnt;

  f_pc_unit dut (
    .clk          (clk),
    .reset        (reset),
    .F_en         (F_en),
    .D_br_type    (D_br_type),
    .D_equal      (D_equal),
    .D_pc         (D_pc),
    .D_imm16      (D_imm16),
    .D_imm26      (D_imm26),
    .D_Rdata1     (D_Rdata1),
    .F_pc         (F_pc),
    .F_adel       (F_adel),
    .redirect     (redirect),
    .redirect_cnt (redirect_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        en;
    logic [2:0]  br_type;
    logic        equal;
    logic [31:0] dpc;
    logic [15:0] imm16;
    logic [25:0] imm26;
    logic [31:0] rdata1;
    logic        exp_redirect;
    logic [31:0] exp_pc;
    logic        exp_adel;
    logic [31:0] exp_cnt;
  } vec_t;

  localparam int NVEC = 19;
  vec_t vecs [NVEC];

  int n_cmp = 0;
  int n_err = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic drive(input vec_t v);
    F_en      = v.en;
    D_br_type = v.br_type;
    D_equal   = v.equal;
    D_pc      = v.dpc;
    D_imm16   = v.imm16;
    D_imm26   = v.imm26;
    D_Rdata1  = v.rdata1;
  endtask

  initial begin
    // en type eq D_pc imm16 imm26 rdata1 | redirect F_pc adel cnt (after the edge)
    vecs[0]  = '{1'b1, 3'b000, 1'b0, 32'h0, 16'h0, 26'h0, 32'h0,          1'b0, 32'h0000_3004, 1'b0, 32'd0};
    vecs[1]  = '{1'b1, 3'b000, 1'b0, 32'h0, 16'h0, 26'h0, 32'h0,          1'b0, 32'h0000_3008, 1'b0, 32'd0};
    // branch not taken: sequential, not counted
    vecs[2]  = '{1'b1, 3'b001, 1'b0, 32'h3004, 16'hFFFF, 26'h0, 32'h0,    1'b0, 32'h0000_300C, 1'b0, 32'd0};
    // branch taken: 3008 - 4
    vecs[3]  = '{1'b1, 3'b001, 1'b1, 32'h3004, 16'hFFFF, 26'h0, 32'h0,    1'b1, 32'h0000_3004, 1'b0, 32'd1};
    // jump: {0, C40, 00} = 3100
    vecs[4]  = '{1'b1, 3'b010, 1'b0, 32'h3010, 16'h0, 26'h0000C40, 32'h0, 1'b1, 32'h0000_3100, 1'b0, 32'd2};
    // jr to misaligned address
    vecs[5]  = '{1'b1, 3'b011, 1'b0, 32'h0, 16'h0, 26'h0, 32'h0000_3202,  1'b1, 32'h0000_3202, 1'b1, 32'd3};
    vecs[6]  = '{1'b1, 3'b000, 1'b0, 32'h0, 16'h0, 26'h0, 32'h0,          1'b0, 32'h0000_3206, 1'b1, 32'd3};
    vecs[7]  = '{1'b1, 3'b011, 1'b0, 32'h0, 16'h0, 26'h0, 32'h0000_3300,  1'b1, 32'h0000_3300, 1'b0, 32'd4};
    // 1xx types act as none, even with D_equal=1
    vecs[8]  = '{1'b1, 3'b100, 1'b1, 32'h3004, 16'hFFFF, 26'h0, 32'h0,    1'b0, 32'h0000_3304, 1'b0, 32'd4};
    vecs[9]  = '{1'b1, 3'b111, 1'b1, 32'h3004, 16'hFFFF, 26'h0, 32'h0,    1'b0, 32'h0000_3308, 1'b0, 32'd4};
    // stalled taken branch (target 3008+0x40=3048) for 3 edges, then released
    vecs[10] = '{1'b0, 3'b001, 1'b1, 32'h3004, 16'h0010, 26'h0, 32'h0,    1'b1, 32'h0000_3308, 1'b0, 32'd4};
    vecs[11] = '{1'b0, 3'b001, 1'b1, 32'h3004, 16'h0010, 26'h0, 32'h0,    1'b1, 32'h0000_3308, 1'b0, 32'd4};
    vecs[12] = '{1'b0, 3'b001, 1'b1, 32'h3004, 16'h0010, 26'h0, 32'h0,    1'b1, 32'h0000_3308, 1'b0, 32'd4};
    vecs[13] = '{1'b1, 3'b001, 1'b1, 32'h3004, 16'h0010, 26'h0, 32'h0,    1'b1, 32'h0000_3048, 1'b0, 32'd5};
    // backward branch wraps below zero: 4 - 0x20000
    vecs[14] = '{1'b1, 3'b001, 1'b1, 32'h0, 16'h8000, 26'h0, 32'h0,       1'b1, 32'hFFFE_0004, 1'b0, 32'd6};
    // sequential wrap at top of address space
    vecs[15] = '{1'b1, 3'b011, 1'b0, 32'h0, 16'h0, 26'h0, 32'hFFFF_FFFC,  1'b1, 32'hFFFF_FFFC, 1'b0, 32'd7};
    vecs[16] = '{1'b1, 3'b000, 1'b0, 32'h0, 16'h0, 26'h0, 32'h0,          1'b0, 32'h0000_0000, 1'b0, 32'd7};
    // jump keeps upper nibble of D_pc+4
    vecs[17] = '{1'b1, 3'b010, 1'b0, 32'hA000_0000, 16'h0, 26'h3FF_FFFF, 32'h0, 1'b1, 32'hAFFF_FFFC, 1'b0, 32'd8};
    vecs[18] = '{1'b1, 3'b011, 1'b0, 32'h0, 16'h0, 26'h0, 32'h0000_3100,  1'b1, 32'h0000_3100, 1'b0, 32'd9};

    reset     = 1'b0;
    F_en      = 1'b0;
    D_br_type = 3'b000;
    D_equal   = 1'b0;
    D_pc      = '0;
    D_imm16   = '0;
    D_imm26   = '0;
    D_Rdata1  = '0;

    repeat (2) @(negedge clk);
    check("reset F_pc", F_pc, 32'h0000_3000);
    check("reset F_adel", 32'(F_adel), 32'd0);
    check("reset redirect_cnt", redirect_cnt, 32'd0);
    check("reset redirect", 32'(redirect), 32'd0);
    reset = 1'b1;

    for (int i = 0; i < NVEC; i++) begin
      @(negedge clk);
      drive(vecs[i]);
      #1;
      check($sformatf("vec%0d redirect", i), 32'(redirect), 32'(vecs[i].exp_redirect));
      @(posedge clk);
      #1;
      check($sformatf("vec%0d F_pc", i), F_pc, vecs[i].exp_pc);
      check($sformatf("vec%0d F_adel", i), 32'(F_adel), 32'(vecs[i].exp_adel));
      check($sformatf("vec%0d redirect_cnt", i), redirect_cnt, vecs[i].exp_cnt);
    end

    // Reset pulsed between edges while a taken branch is pending at F_pc=3100.
    @(negedge clk);
    F_en      = 1'b1;
    D_br_type = 3'b001;
    D_equal   = 1'b1;
    D_pc      = 32'h0000_3004;
    D_imm16   = 16'hFFFF;
    #1;
    check("pre-reset F_pc", F_pc, 32'h0000_3100);
    #1;
    reset = 1'b0;
    #1;
    check("mid reset F_pc", F_pc, 32'h0000_3000);
    check("mid reset redirect_cnt", redirect_cnt, 32'd0);
    check("mid reset redirect", 32'(redirect), 32'd1);
    reset = 1'b1;
    @(posedge clk);
    #1;
    check("post reset F_pc", F_pc, 32'h0000_3004);
    check("post reset redirect_cnt", redirect_cnt, 32'd1);

    // Reset during a stall: stalled redirect is dropped.
    @(negedge clk);
    F_en      = 1'b0;
    D_br_type = 3'b011;
    D_Rdata1  = 32'h0000_4001;
    @(posedge clk);
    #1;
    check("stall hold F_pc", F_pc, 32'h0000_3004);
    reset = 1'b0;
    #1;
    check("stall reset F_pc", F_pc, 32'h0000_3000);
    check("stall reset redirect_cnt", redirect_cnt, 32'd0);
    check("stall reset F_adel", 32'(F_adel), 32'd0);
    @(negedge clk);
    reset     = 1'b1;
    F_en      = 1'b1;
    D_br_type = 3'b000;
    @(posedge clk);
    #1;
    check("after stall reset F_pc", F_pc, 32'h0000_3004);
    check("after stall reset redirect_cnt", redirect_cnt, 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/f_pc_unit.md
# f_pc_unit

Fetch-stage program counter register and next-PC selector for the five-stage MIPS pipeline. It consumes the decode-stage branch/jump decision: branch type and comparator result from D, jump targets, and the forwarded `jr` register value. It sequences F_pc through sequential fetch, branch, jump and register-jump redirects, honouring the single architectural delay slot. It also honours the hazard unit's stall, flags misaligned fetch addresses, and counts taken redirects for the performance counters.

## Interface
- RESET_PC, 32'h0000_3000, fetch address loaded on reset.
- clk  input  1  system clock; all state updates on rising edge.
- reset  input  1  asynchronous, active-low; clears all state immediately on assertion.
- F_en  input  1  1 = F_pc may advance; 0 = stall (hold everything).
- D_br_type  input  3  000 none, 001 conditional branch, 010 j/jal, 011 jr/jalr; 1xx treated as none.
- D_equal  input  1  branch condition true for the instruction in D.
- D_pc  input  32  PC of the instruction currently in D.
- D_imm16  input  16  branch offset field.
- D_imm26  input  26  jump index field.
- D_Rdata1  input  32  forwarded rs value, used as the jr/jalr target.
- F_pc  output  32  current fetch address.
- F_adel  output  1  registered; 1 when F_pc[1:0] != 0.
- redirect  output  1  combinational; this cycle's next PC is a non-sequential target.
- redirect_cnt  output  32  count of committed redirects.

## Operation
- Sequential next PC: F_pc + 4, 32-bit modular.
- Branch target: D_pc + 4 + (sign_extend(D_imm16) << 2), 32-bit wrap, no overflow flag.
- Jump target: {D_pc_plus4[31:28], D_imm26, 2'b00}, where D_pc_plus4 = D_pc + 4.
- Register target: D_Rdata1 unmodified, including low bits.
- Selection priority:
  - D_br_type 011 gives the register target.
  - 010 gives the jump target.
  - 001 with D_equal=1 gives the branch target.
  - Otherwise the next PC is F_pc + 4.
- redirect = 1 exactly when a non-sequential target is selected.
- Delay slot: the instruction already in F (at D_pc+4) is not flushed. The redirect replaces only the following fetch.
- Update on rising edge when F_en=1:
  - F_pc <= next PC.
  - F_adel <= (next PC[1:0] != 0).
  - If redirect=1, redirect_cnt increments (wraps at 2^32).
- When F_en=0: F_pc, F_adel and redirect_cnt hold. redirect is still computed but not committed; because D is also frozen, the same redirect is presented again after the stall.
- Misaligned target: still loaded into F_pc; F_adel raised for that fetch. Exception handling is downstream; this block does not block fetch.

## Timing
- Reset (reset=0, async): F_pc = RESET_PC, F_adel = 0, redirect_cnt = 0. redirect follows its inputs combinationally.
- First advance happens on the first rising edge after reset deasserts with F_en=1.
- Latency: a redirect decided in D in cycle n appears on F_pc in cycle n+1 (one edge). No bubble is inserted beyond the delay slot.
- Stall then release: F_pc after release equals the value that would have been loaded at the first stalled edge.
- Reset asserted mid-stall or mid-redirect: reset wins immediately; the pending redirect is lost.
- F_pc = 32'hFFFF_FFFC with sequential fetch wraps to 32'h0000_0000; F_adel stays 0.
- D_br_type 001 with D_equal=0 is not a redirect and is not counted.

## Test plan
- Reset release with F_en=1 for 3 edges -> F_pc = 3000, 3004, 3008, 300C; redirect_cnt = 0.
- D_pc=3004, type 001, D_equal=1, imm16=16'hFFFF at F_pc=3008 -> next F_pc=3004; redirect_cnt=1. Same stimulus with D_equal=0 -> 300C; count unchanged.
- Type 010, D_pc=3010, imm26=26'h0000C40 -> F_pc=00003100; redirect=1.
- Type 011, D_Rdata1=00003202 -> F_pc=00003202, F_adel=1. Next sequential fetch 00003206 keeps F_adel=1. Then jr to 3300 -> F_adel=0.
- Branch redirect presented with F_en=0 for 3 cycles, then F_en=1 -> F_pc holds 3 cycles, then loads target; redirect_cnt increments by exactly 1.
- reset pulsed low between edges while F_pc=3100 -> F_pc=3000 and redirect_cnt=0 before the next edge.
